// File: rtl/sonic_echo_responder.sv
// sonic_echo_responder: stands in for an ultrasonic ranging module.
// It accepts a trigger pulse of at least TRIG_MIN cycles, waits BURST_DLY
// cycles after the trigger's falling edge, then drives an echo pulse whose
// high time is echo_cycles (clamped to 1..ECHO_MAX, 0 means "no object").
// Build option: define SONIC_HOLDOFF_EN to add a HOLDOFF-cycle dead time
// after each echo during which triggers are ignored.
module sonic_echo_responder #(
  parameter int unsigned TRIG_MIN  = 500,
  parameter int unsigned BURST_DLY = 25000,
  parameter int unsigned ECHO_MAX  = 1900000,
  parameter int unsigned HOLDOFF   = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trig,
  input  logic [23:0] echo_cycles,
  output logic        echo,
  output logic        busy,
  output logic        trig_err,
  output logic [7:0]  meas_count
);

  localparam logic [23:0] TRIG_MIN_C  = 24'(TRIG_MIN);
  localparam logic [23:0] ECHO_MAX_C  = 24'(ECHO_MAX);
  localparam logic [23:0] BURST_END_C = 24'(BURST_DLY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG_HI,
    S_BURST,
`ifdef SONIC_HOLDOFF_EN
    S_HOLD,
`endif
    S_ECHO
  } state_t;

  state_t      state_reg;
  logic [23:0] cnt_reg;
  logic [23:0] len_reg;
  logic [23:0] len_next;
  logic        t1_reg;
  logic        t2_reg;
  logic        echo_reg;
  logic        busy_reg;
  logic        trig_err_reg;
  logic [7:0]  meas_count_reg;
  logic        trig_rise;
  logic        trig_fall;

`ifdef SONIC_HOLDOFF_EN
  localparam logic [23:0] HOLDOFF_C = 24'(HOLDOFF);
`else
  // HOLDOFF only matters when the hold-off dead time is built in.
  logic holdoff_unused;
  assign holdoff_unused = (HOLDOFF == 0);
`endif

  assign trig_rise = t1_reg & ~t2_reg;
  assign trig_fall = ~t1_reg & t2_reg;

  // Clamp the requested echo length: 0 and anything above ECHO_MAX mean "no object".
  always_comb begin
    len_next = echo_cycles;
    if ((echo_cycles == 24'd0) || (echo_cycles > ECHO_MAX_C)) begin
      len_next = ECHO_MAX_C;
    end
  end

  // Trigger synchronizer plus measurement FSM; every output is a register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t1_reg         <= 1'b0;
      t2_reg         <= 1'b0;
      state_reg      <= S_IDLE;
      cnt_reg        <= 24'd0;
      len_reg        <= 24'd0;
      echo_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      trig_err_reg   <= 1'b0;
      meas_count_reg <= 8'd0;
    end else begin
      t1_reg       <= trig;
      t2_reg       <= t1_reg;
      trig_err_reg <= 1'b0;
      unique case (state_reg)
        S_IDLE: begin
          if (trig_rise) begin
            state_reg <= S_TRIG_HI;
            cnt_reg   <= 24'd1;
          end
        end
        S_TRIG_HI: begin
          if (trig_fall) begin
            if (cnt_reg >= TRIG_MIN_C) begin
              len_reg  <= len_next;
              busy_reg <= 1'b1;
              cnt_reg  <= 24'd1;
              // With a one-cycle burst the echo must rise right away.
              if (BURST_DLY <= 1) begin
                state_reg <= S_ECHO;
                echo_reg  <= 1'b1;
              end else begin
                state_reg <= S_BURST;
              end
            end else begin
              trig_err_reg <= 1'b1;
              state_reg    <= S_IDLE;
              cnt_reg      <= 24'd0;
            end
          end else if (cnt_reg < TRIG_MIN_C) begin
            cnt_reg <= cnt_reg + 24'd1;
          end
        end
        S_BURST: begin
          if (cnt_reg >= BURST_END_C) begin
            state_reg <= S_ECHO;
            echo_reg  <= 1'b1;
            cnt_reg   <= 24'd1;
          end else begin
            cnt_reg <= cnt_reg + 24'd1;
          end
        end
        S_ECHO: begin
          if (cnt_reg >= len_reg) begin
            echo_reg       <= 1'b0;
            meas_count_reg <= meas_count_reg + 8'd1;
`ifdef SONIC_HOLDOFF_EN
            state_reg      <= S_HOLD;
            cnt_reg        <= 24'd1;
`else
            state_reg      <= S_IDLE;
            busy_reg       <= 1'b0;
            cnt_reg        <= 24'd0;
`endif
          end else begin
            cnt_reg <= cnt_reg + 24'd1;
          end
        end
`ifdef SONIC_HOLDOFF_EN
        S_HOLD: begin
          if (cnt_reg >= HOLDOFF_C) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
            cnt_reg   <= 24'd0;
          end else begin
            cnt_reg <= cnt_reg + 24'd1;
          end
        end
`endif
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          echo_reg  <= 1'b0;
          cnt_reg   <= 24'd0;
        end
      endcase
    end
  end

  assign echo       = echo_reg;
  assign busy       = busy_reg;
  assign trig_err   = trig_err_reg;
  assign meas_count = meas_count_reg;

endmodule

// File: tb/tb_sonic_echo_responder.sv
// Bench for sonic_echo_responder with scaled-down timing parameters.
// An event-level model predicts echo/busy/trig_err/meas_count windows from
// the trigger pulses; directed tests pin the model with literal numbers.
module tb_sonic_echo_responder;
  localparam int TMIN = 8;
  localparam int D    = 20;
  localparam int EMAX = 200;
  localparam int H    = 50;
`ifdef SONIC_HOLDOFF_EN
  localparam int HX = H;
`else
  localparam int HX = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig = 1'b0;
  logic [23:0] echo_cycles = 24'd0;
  logic        echo;
  logic        busy;
  logic        trig_err;
  logic [7:0]  meas_count;

  int n_cmp = 0;
  int n_bad = 0;

  sonic_echo_responder #(
    .TRIG_MIN(TMIN), .BURST_DLY(D), .ECHO_MAX(EMAX), .HOLDOFF(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .echo_cycles(echo_cycles),
    .echo(echo), .busy(busy), .trig_err(trig_err), .meas_count(meas_count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model (pulse/window level) ----------------
  longint cyc = 0;
  bit     m_valid = 0;
  bit     s_prev, tracking, m_rise, m_fall;
  longint rise_cyc, acc_cyc, e_start, e_end, idle_at, err_at, m_len;
  int     m_count;
  bit     exp_echo, exp_busy, exp_err;
  logic [7:0] exp_mc;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_valid = 1; s_prev = 0; tracking = 0;
      acc_cyc = -1; e_start = -1; e_end = -1; idle_at = 0; err_at = -1;
      m_count = 0;
    end else begin
      m_rise = trig && !s_prev;
      m_fall = !trig && s_prev;
      if (m_rise && !tracking && cyc >= idle_at) begin
        tracking = 1;
        rise_cyc = cyc;
      end else if (m_fall && tracking) begin
        tracking = 0;
        if (cyc - rise_cyc >= TMIN) begin
          m_len   = (echo_cycles == 0 || echo_cycles > EMAX) ? EMAX : echo_cycles;
          acc_cyc = cyc;
          e_start = cyc + D;
          e_end   = e_start + m_len;
          idle_at = e_end + HX;
        end else begin
          err_at = cyc + 1;
        end
      end
      s_prev = trig;
      if (cyc == e_end) m_count++;
    end
    exp_echo = (cyc >= e_start) && (cyc < e_end);
    exp_busy = (acc_cyc >= 0) && (cyc > acc_cyc) && (cyc < idle_at);
    exp_err  = (cyc == err_at);
    exp_mc   = m_count[7:0];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("echo", echo, exp_echo);
      chk("busy", busy, exp_busy);
      chk("trig_err", trig_err, exp_err);
      chk("meas_count", meas_count, exp_mc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_now(input int w, input logic [23:0] ec);
    echo_cycles = ec;
    trig = 1'b1;
    repeat (w) @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic pulse(input int w, input logic [23:0] ec);
    @(negedge clk);
    pulse_now(w, ec);
  endtask

  // Called right after trig drops; returns delay and high time of the echo.
  task automatic measure(output int dly, output int wid);
    dly = 0;
    wid = 0;
    while (dly < 2000) begin
      @(negedge clk);
      dly++;
      if (echo) break;
    end
    if (!echo) begin
      chk("echo_rise_timeout", 0, 1);
    end else begin
      while (echo && wid < 5000) begin
        wid++;
        @(negedge clk);
      end
      if (echo) chk("echo_fall_timeout", 0, 1);
    end
    $display("measure: delay=%0d width=%0d meas_count=%0d", dly, wid, meas_count);
  endtask

  // Counts echo rises, trig_err pulses and busy cycles over a window.
  task automatic observe(input int n, output int rises, output int errs, output int busys);
    logic prev;
    rises = 0; errs = 0; busys = 0;
    prev = echo;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (echo && !prev) rises++;
      if (trig_err) errs++;
      if (busy) busys++;
      prev = echo;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dly, wid, rises, errs, busys, gap, w, sel;
    logic [23:0] ec;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_echo", echo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_meas_count", meas_count, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Minimum-width trigger, normal echo
    pulse(TMIN, 24'd150);
    measure(dly, wid);
    chk("dir_delay", dly, D + 1);
    chk("dir_width", wid, 150);
    chk("dir_count", meas_count, 1);
    repeat (70) @(negedge clk);

    // One cycle too short: single trig_err pulse, nothing else
    pulse(TMIN - 1, 24'd150);
    observe(60, rises, errs, busys);
    $display("short trig: rises=%0d errs=%0d busy_cycles=%0d", rises, errs, busys);
    chk("short_err_pulses", errs, 1);
    chk("short_echo_rises", rises, 0);
    chk("short_busy", busys, 0);
    chk("short_count", meas_count, 1);

    // Echo length clamping
    pulse(TMIN, 24'd0);        measure(dly, wid); chk("len_zero", wid, EMAX);
    repeat (70) @(negedge clk);
    pulse(TMIN, 24'(EMAX + 1)); measure(dly, wid); chk("len_over", wid, EMAX);
    repeat (70) @(negedge clk);
    pulse(TMIN, 24'hFFFFFF);   measure(dly, wid); chk("len_max24", wid, EMAX);
    repeat (70) @(negedge clk);
    pulse(TMIN, 24'd1);        measure(dly, wid); chk("len_one", wid, 1);
    chk("clamp_count", meas_count, 5);
    repeat (70) @(negedge clk);

    // Retrigger during ECHO is ignored
    pulse(TMIN, 24'd100);
    repeat (30) @(negedge clk);
    pulse_now(TMIN, 24'd40);
    observe(400, rises, errs, busys);
    chk("retrig_rises", rises, 0);
    chk("retrig_errs", errs, 0);
    chk("retrig_count", meas_count, 6);

    // Reset in the middle of ECHO
    pulse(TMIN, 24'd100);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_echo", echo, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_count", meas_count, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    pulse(TMIN, 24'd60);
    measure(dly, wid);
    chk("post_reset_delay", dly, D + 1);
    chk("post_reset_width", wid, 60);
    chk("post_reset_count", meas_count, 1);
    repeat (70) @(negedge clk);

`ifdef SONIC_HOLDOFF_EN
    // Trigger inside the hold-off window is ignored, just after it is accepted
    pulse(TMIN, 24'd30);
    measure(dly, wid);
    repeat (19) @(negedge clk);
    pulse_now(TMIN, 24'd30);
    observe(150, rises, errs, busys);
    chk("holdoff_ignored", rises, 0);
    pulse(TMIN, 24'd30);
    measure(dly, wid);
    repeat (H) @(negedge clk);
    pulse_now(TMIN, 24'd30);
    measure(dly, wid);
    chk("holdoff_accept_delay", dly, D + 1);
    chk("holdoff_accept_width", wid, 30);
    repeat (70) @(negedge clk);
`endif

    // Randomized pulses, lengths and occasional resets
    for (int i = 0; i < 150; i++) begin
      gap = $urandom_range(2, 120);
      w   = $urandom_range(1, TMIN + 6);
      sel = $urandom_range(0, 5);
      case (sel)
        0: ec = 24'd0;
        1: ec = 24'(EMAX);
        2: ec = 24'(EMAX + 1);
        3: ec = 24'hFFFFFF;
        default: ec = 24'($urandom_range(1, EMAX));
      endcase
      repeat (gap) @(negedge clk);
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      pulse(w, ec);
      $display("rand %0d: width=%0d echo_cycles=%0d meas_count=%0d", i, w, ec, meas_count);
    end
    repeat (400) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sonic_echo_responder.md
Name: sonic_echo_responder

Overview:
- Models the ultrasonic ranging module seen from the FPGA side.
- Accepts the trigger pulse produced by the sonic distance initiator, waits a fixed burst delay, then drives an echo pulse whose high time is a programmable number of clock cycles.
- Used for hardware-in-loop bring-up of the obstacle-detect path without a physical sensor, and as the echo source in block-level benches.

Parameters:
- TRIG_MIN, 500, minimum synchronized trig high time in cycles for a valid trigger (10 us at 50 MHz).
- BURST_DLY, 25000, cycles from accepted trig falling edge to echo rising edge.
- ECHO_MAX, 1900000, maximum echo high time in cycles, also the "no object" width (38 ms).
- HOLDOFF, 50000, cycles after echo falls during which triggers are ignored (used only with the optional feature).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, synchronous, active-low.
- trig  in  1  trigger from the initiator; asynchronous to clk.
- echo_cycles  in  24  requested echo high time in cycles; sampled once per measurement.
- echo  out  1  echo pulse to the initiator.
- busy  out  1  high from trigger acceptance until the responder is ready for the next trigger.
- trig_err  out  1  one-cycle pulse when a trig pulse shorter than TRIG_MIN ends.
- meas_count  out  8  count of completed echo pulses; wraps 255->0.

Behaviour:
- Reset (rst_n low at a clk edge): echo=0, busy=0, trig_err=0, meas_count=0, all counters 0, state=IDLE, synchronizer flops 0. Reset mid-measurement aborts immediately; echo is low on the first cycle after reset.
- trig passes through a 2-flop synchronizer (t1, t2). Rise = t1&~t2; fall = ~t1&t2.
- IDLE:
  - On rise: go to TRIG_HI, width counter=1.
  - A fall seen in IDLE is ignored.
- TRIG_HI:
  - Increment the width counter each cycle, saturating at TRIG_MIN.
  - On fall with counter>=TRIG_MIN: sample echo_cycles into the echo length register L, go to BURST, busy=1.
  - On fall with counter<TRIG_MIN: pulse trig_err for 1 cycle, return to IDLE.
  - A trig stuck high keeps the state in TRIG_HI indefinitely.
- L rules:
  - L = echo_cycles when 1 <= echo_cycles <= ECHO_MAX.
  - echo_cycles==0 yields L=ECHO_MAX (no object).
  - echo_cycles>ECHO_MAX saturates L to ECHO_MAX.
- BURST: count BURST_DLY cycles, then go to ECHO. Echo rises exactly BURST_DLY cycles after the cycle in which the fall was detected.
- ECHO:
  - echo=1 for exactly L cycles, then echo=0.
  - meas_count increments on the cycle echo falls.
  - Next state is IDLE, or HOLD when the feature is enabled.
- busy: 1 in BURST, ECHO and HOLD; 0 in IDLE and TRIG_HI.
- Any trig activity while busy=1 is ignored; no retrigger, no trig_err.
- Trig edges in the same cycle as the ECHO->IDLE transition are not captured. A trig already high at that point does not register until a fresh rise.
- Echo is registered and glitch-free.
- Counters are 24 bits wide; no counter wraps within a measurement.

Optional Feature:
- Macro: SONIC_HOLDOFF_EN.
- Defined: after echo falls, the FSM enters HOLD for HOLDOFF cycles with busy=1, and trig is ignored throughout. It then returns to IDLE.
- Undefined: no HOLD state; the FSM returns to IDLE directly after ECHO, busy falls with echo, and the HOLDOFF parameter is unused.

Test Plan:
- Trig high 500 cycles, echo_cycles=150000 -> echo rises 25000 cycles after the detected fall and stays high exactly 150000 cycles; busy high throughout; meas_count 0->1; trig_err stays 0.
- Trig high 499 cycles -> trig_err pulses for exactly 1 cycle, echo stays 0, busy stays 0, meas_count unchanged.
- echo_cycles=0, then a separate run with echo_cycles=2000000 -> echo high 1900000 cycles in each case.
- Second 500-cycle trig issued during the ECHO phase of the first -> ignored; only one echo pulse; meas_count increments by 1.
- rst_n low for 1 cycle mid-ECHO -> echo=0 and busy=0 the next cycle, meas_count=0; a new valid trig afterwards produces a normal echo.
- With SONIC_HOLDOFF_EN defined, trig issued 1000 cycles after echo falls -> ignored; trig issued 50001 cycles after echo falls -> accepted, new echo produced.
